// File: rtl/beep_melody_ctrl.sv
// Buzzer melody sequencer: walks a fixed 14-note table, drives period/enable to the tone generator.
// Build option: define LOOP_PLAY_EN to replay the song continuously instead of stopping after one pass.
module beep_melody_ctrl #(
    parameter logic [24:0] CNT_BEAT = 25'd24_999_999,
    parameter logic [24:0] CNT_GAP  = 25'd2_499_999,
    parameter logic [3:0]  SONG_LEN = 4'd14,
    parameter logic [17:0] DO       = 18'd190839,
    parameter logic [17:0] RE       = 18'd170067,
    parameter logic [17:0] MI       = 18'd151514,
    parameter logic [17:0] FA       = 18'd143265,
    parameter logic [17:0] SO       = 18'd127550,
    parameter logic [17:0] LA       = 18'd113635,
    parameter logic [17:0] XI       = 18'd101213
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        stop,
    output logic        tone_en,
    output logic [17:0] freq_data,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W  = 25;
    localparam int unsigned FREQ_W = 18;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        FINISH
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    beat_cnt;
    logic [BEAT_W-1:0]   beat_idx;
    logic [CNT_W-1:0]    gap_cnt;

    // Note table: code 0 is a rest, 1..7 are DO..XI
    function automatic logic [CODE_W-1:0] note_code(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    note_code = 3'd1;
            4'd1:    note_code = 3'd2;
            4'd2:    note_code = 3'd3;
            4'd3:    note_code = 3'd4;
            4'd4:    note_code = 3'd5;
            4'd5:    note_code = 3'd6;
            4'd6:    note_code = 3'd7;
            4'd7:    note_code = 3'd0;
            4'd8:    note_code = 3'd6;
            4'd9:    note_code = 3'd5;
            4'd10:   note_code = 3'd4;
            4'd11:   note_code = 3'd3;
            4'd12:   note_code = 3'd2;
            4'd13:   note_code = 3'd1;
            default: note_code = 3'd0;
        endcase
    endfunction

    function automatic logic [BEAT_W-1:0] note_beats(input logic [IDX_W-1:0] idx);
        note_beats = (idx == 4'd13) ? 3'd2 : 3'd1;
    endfunction

    function automatic logic [FREQ_W-1:0] code_period(input logic [CODE_W-1:0] code);
        case (code)
            3'd2:    code_period = RE;
            3'd3:    code_period = MI;
            3'd4:    code_period = FA;
            3'd5:    code_period = SO;
            3'd6:    code_period = LA;
            3'd7:    code_period = XI;
            default: code_period = DO;
        endcase
    endfunction

    logic [CODE_W-1:0] cur_code;
    logic [BEAT_W-1:0] cur_beats;
    logic              beat_end;
    logic              last_beat;
    logic              gap_end;
    logic              last_note;

    assign cur_code  = note_code(note_idx);
    assign cur_beats = note_beats(note_idx);
    assign beat_end  = (beat_cnt == CNT_BEAT);
    assign last_beat = (beat_idx == BEAT_W'(cur_beats - BEAT_W'(1)));
    // The following LOAD cycle is silent too and supplies the last clock of the gap,
    // so GAP itself lasts CNT_GAP clocks (at least one).
    assign gap_end   = ((CNT_W+1)'(gap_cnt) + (CNT_W+1)'(1)) >= (CNT_W+1)'(CNT_GAP);
    assign last_note = (note_idx == IDX_W'(SONG_LEN - 4'd1));

    // Sequencer FSM with registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            tone_en   <= 1'b0;
            freq_data <= DO;
            note_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            beat_cnt  <= '0;
            beat_idx  <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (stop && (state != IDLE)) begin
                state    <= IDLE;
                tone_en  <= 1'b0;
                busy     <= 1'b0;
                note_idx <= '0;
                beat_cnt <= '0;
                beat_idx <= '0;
                gap_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            note_idx <= '0;
                            beat_cnt <= '0;
                            beat_idx <= '0;
                            gap_cnt  <= '0;
                        end
                    end
                    LOAD: begin
                        // A rest keeps the previous period and only silences the output
                        if (cur_code != 3'd0) begin
                            freq_data <= code_period(cur_code);
                        end
                        tone_en  <= (cur_code != 3'd0);
                        state    <= PLAY;
                        beat_cnt <= '0;
                        beat_idx <= '0;
                    end
                    PLAY: begin
                        if (beat_end) begin
                            beat_cnt <= '0;
                            if (last_beat) begin
                                state    <= GAP;
                                tone_en  <= 1'b0;
                                beat_idx <= '0;
                                gap_cnt  <= '0;
                            end else begin
                                beat_idx <= beat_idx + BEAT_W'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            gap_cnt <= '0;
                            if (last_note) begin
`ifdef LOOP_PLAY_EN
                                note_idx <= '0;
                                state    <= LOAD;
`else
                                note_idx <= '0;
                                state    <= FINISH;
                                done     <= 1'b1;
                                busy     <= 1'b0;
`endif
                            end else begin
                                note_idx <= note_idx + IDX_W'(1);
                                state    <= LOAD;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + CNT_W'(1);
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beep_melody_ctrl.sv
// Bench for beep_melody_ctrl: timeline model of the song checked every cycle, plus literal pins.
module tb_beep_melody_ctrl;

    localparam int CB = 9;
    localparam int CG = 1;
`ifdef LOOP_PLAY_EN
    localparam int SL   = 3;
    localparam bit LOOP = 1'b1;
`else
    localparam int SL   = 14;
    localparam bit LOOP = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        tone_en;
    logic [17:0] freq_data;
    logic [3:0]  note_idx;
    logic        busy;
    logic        done;

    beep_melody_ctrl #(
        .CNT_BEAT(25'(CB)),
        .CNT_GAP (25'(CG)),
        .SONG_LEN(4'(SL))
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .start    (start),
        .stop     (stop),
        .tone_en  (tone_en),
        .freq_data(freq_data),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // ---- song model: every note is LOAD(1) + beats*(CB+1) sounding + CG silent clocks ----
    function automatic int code_of(input int k);
        case (k)
            0, 1, 2, 3, 4, 5, 6: return k + 1;
            7:  return 0;
            8:  return 6;
            9:  return 5;
            10: return 4;
            11: return 3;
            12: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int period_of(input int c);
        case (c)
            1: return 190839;
            2: return 170067;
            3: return 151514;
            4: return 143265;
            5: return 127550;
            6: return 113635;
            7: return 101213;
            default: return 0;
        endcase
    endfunction

    function automatic int beats_of(input int k);
        return (k == 13) ? 2 : 1;
    endfunction

    function automatic int len_of(input int k);
        return 1 + beats_of(k) * (CB + 1) + CG;
    endfunction

    function automatic int total_len();
        int s = 0;
        for (int k = 0; k < SL; k++) s += len_of(k);
        return s;
    endfunction

    localparam int T = total_len();

    function automatic void locate(input int t, output int k, output int u);
        int rem = t;
        k = 0;
        while (k < SL - 1 && rem >= len_of(k)) begin
            rem -= len_of(k);
            k++;
        end
        u = rem;
    endfunction

    function automatic bit next_act(input bit act, input int t, input bit st, input bit sp);
        if (act) return !(sp || (!LOOP && t == T));
        return st && !sp;
    endfunction

    function automatic int next_t(input bit act, input int t, input bit st, input bit sp);
        if (act) begin
            if (sp || (!LOOP && t == T)) return t;
            return LOOP ? (t + 1) % T : t + 1;
        end
        return (st && !sp) ? 0 : t;
    endfunction

    function automatic int next_freq(input bit na, input int nt, input int f);
        int k, u;
        if (na && nt < T) begin
            locate(nt, k, u);
            if (u >= 1 && code_of(k) != 0) return period_of(code_of(k));
        end
        return f;
    endfunction

    bit m_active;
    int m_t;
    int m_freq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_freq   <= 190839;
        end else begin
            m_active <= next_act(m_active, m_t, start, stop);
            m_t      <= next_t(m_active, m_t, start, stop);
            m_freq   <= next_freq(next_act(m_active, m_t, start, stop),
                                  next_t(m_active, m_t, start, stop), m_freq);
        end
    end

    // ---- checking state (all written by the stimulus process only) ----
    int n_cmp = 0;
    int n_err = 0;
    int c0_on = 0, c0_off = 0, c7_off = 0, c13_on = 0, c_done = 0, c_wrap = 0;
    int f_idx1 = 0;
    int prev_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, compare DUT against the model, update run counters
    task automatic tick();
        int e_tone, e_idx, e_busy, e_done, k, u;
        @(negedge clk);
        e_tone = 0; e_idx = 0; e_busy = 0; e_done = 0;
        if (m_active) begin
            if (!LOOP && m_t == T) begin
                e_done = 1;
            end else begin
                locate(m_t, k, u);
                e_idx  = k;
                e_busy = 1;
                e_tone = (u >= 1 && u <= beats_of(k) * (CB + 1) && code_of(k) != 0) ? 1 : 0;
            end
        end
        n_cmp++;
        if (int'(tone_en) != e_tone || int'(freq_data) != m_freq || int'(note_idx) != e_idx ||
            int'(busy) != e_busy || int'(done) != e_done) begin
            n_err++;
            $display("FAIL cycle_model t=%0t: tone %0d/%0d freq %0d/%0d idx %0d/%0d busy %0d/%0d done %0d/%0d (got/expected)",
                     $time, tone_en, e_tone, freq_data, m_freq, note_idx, e_idx, busy, e_busy, done, e_done);
        end
        if (busy && tone_en && note_idx == 4'd0)   c0_on++;
        if (busy && !tone_en && note_idx == 4'd0)  c0_off++;
        if (busy && !tone_en && note_idx == 4'd7)  c7_off++;
        if (busy && tone_en && note_idx == 4'd13)  c13_on++;
        if (busy && tone_en && note_idx == 4'd1)   f_idx1 = int'(freq_data);
        if (done) c_done++;
        if (busy && note_idx == 4'd0 && prev_idx == SL - 1) c_wrap++;
        prev_idx = int'(note_idx);
    endtask

    task automatic pulse(input bit s, input bit p);
        start = s;
        stop  = p;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_note(input int idx, input string name);
        int n = 0;
        while (!(busy && tone_en && int'(note_idx) == idx) && n < 400) begin
            tick();
            n++;
        end
        chk(name, (n < 400) ? 1 : 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tone"}, int'(tone_en), 0);
        chk({tag, "_freq"}, int'(freq_data), 190839);
        chk({tag, "_idx"},  int'(note_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int b0on, b0off, b7, b13, bd, bw, n;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_vals("reset");

        // Start latency: busy on the accepting edge, first note one edge later
        b0on = c0_on; b0off = c0_off; b7 = c7_off; b13 = c13_on; bd = c_done; bw = c_wrap;
        f_idx1 = 0;
        pulse(1'b1, 1'b0);
        chk("lat_busy", int'(busy), 1);
        chk("lat_tone_off", int'(tone_en), 0);
        tick();
        chk("lat_tone_on", int'(tone_en), 1);
        chk("lat_freq", int'(freq_data), 190839);

        // Start while busy is ignored
        wait_note(2, "wait_idx2");
        pulse(1'b1, 1'b0);

`ifndef LOOP_PLAY_EN
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("pass_timeout", (n < 400) ? 1 : 0, 1);
        chk("end_done", int'(done), 1);
        chk("end_idx", int'(note_idx), 0);
        tick();
        chk("idle_done", int'(done), 0);
        chk("done_pulses", c_done - bd, 1);
        chk("idx0_sound", c0_on - b0on, 10);
        chk("idx0_silent", c0_off - b0off, 2);
        chk("idx1_freq", f_idx1, 170067);
        chk("idx7_silent", c7_off - b7, 12);
        chk("idx13_sound", c13_on - b13, 20);
`else
        repeat (3 * T) tick();
        chk("loop_wraps", c_wrap - bw, 3);
        chk("loop_done", c_done - bd, 0);
        chk("loop_busy", int'(busy), 1);
        pulse(1'b0, 1'b1);
        chk("loop_stop_busy", int'(busy), 0);
        tick();
`endif

        // Abort mid-song
        bd = c_done;
        pulse(1'b1, 1'b0);
        wait_note((SL > 5) ? 5 : 2, "wait_stop_note");
        pulse(1'b0, 1'b1);
        chk("stop_tone", int'(tone_en), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_idx", int'(note_idx), 0);
        repeat (30) tick();
        chk("stop_no_done", c_done - bd, 0);

        // start and stop together from IDLE: stop wins
        pulse(1'b1, 1'b1);
        chk("ss_busy", int'(busy), 0);
        repeat (3) tick();
        chk("ss_busy_later", int'(busy), 0);

        // Asynchronous reset in the middle of a note
        pulse(1'b1, 1'b0);
        wait_note((SL > 3) ? 3 : 1, "wait_rst_note");
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_reset_vals("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
